// File: rtl/add_sub_pipe_if.sv
// Handshake and operand/result bundle for add_sub_pipe.
// The master side produces operands and consumes results; the slave side is the adder pipe.
interface add_sub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;
  logic             flag_c;

  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_v, flag_c
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_v, flag_c
  );
endinterface

// File: rtl/add_sub_pipe.sv
// Two-stage pipelined CLA adder/subtractor with optional signed saturation and NZVC flags.
// Stage 1 resolves the lower half through 4-bit lookahead groups; stage 2 finishes the upper half.
module add_sub_pipe #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  add_sub_pipe_if.slave bus
);
  localparam int HALF    = WIDTH / 2;
  localparam int NGROUPS = HALF / 4;

  logic [WIDTH-1:0] bEff;
  logic [HALF-1:0]  lowGen;
  logic [HALF-1:0]  lowProp;
  logic [HALF-1:0]  lowCarry;
  logic [HALF-1:0]  lowSum;
  logic [NGROUPS:0] grpCarry;

  logic s2Adv;
  logic s1Adv;
  logic s1Load;
  logic s2Load;

  logic            s1Valid_q, s1Valid_d;
  logic [HALF-1:0] lowSum_q;
  logic [HALF-1:0] aHi_q;
  logic [HALF-1:0] bHi_q;
  logic            midCarry_q;
  logic            sat_q;

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flagN_q, flagN_d;
  logic             flagZ_q, flagZ_d;
  logic             flagV_q, flagV_d;
  logic             flagC_q, flagC_d;

  logic [HALF-1:0]  upperLow;
  logic             msbA;
  logic             msbB;
  logic             msbCarryIn;
  logic             msbSum;
  logic             carryOut;
  logic             overflow;
  logic [WIDTH-1:0] rawResult;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  assign bEff    = bus.sub ? ~bus.b : bus.b;
  assign lowGen  = bus.a[HALF-1:0] & bEff[HALF-1:0];
  assign lowProp = bus.a[HALF-1:0] ^ bEff[HALF-1:0];

  // Each group expands its internal carries and its group G | P&cin directly from the group carry-in.
  always_comb begin
    grpCarry    = '0;
    lowCarry    = '0;
    grpCarry[0] = bus.sub;
    for (int g = 0; g < NGROUPS; g++) begin
      lowCarry[4*g]   = grpCarry[g];
      lowCarry[4*g+1] = lowGen[4*g]
                      | (lowProp[4*g] & grpCarry[g]);
      lowCarry[4*g+2] = lowGen[4*g+1]
                      | (lowProp[4*g+1] & lowGen[4*g])
                      | ((&lowProp[4*g +: 2]) & grpCarry[g]);
      lowCarry[4*g+3] = lowGen[4*g+2]
                      | (lowProp[4*g+2] & lowGen[4*g+1])
                      | ((&lowProp[4*g+1 +: 2]) & lowGen[4*g])
                      | ((&lowProp[4*g +: 3]) & grpCarry[g]);
      grpCarry[g+1]   = lowGen[4*g+3]
                      | (lowProp[4*g+3] & lowGen[4*g+2])
                      | ((&lowProp[4*g+2 +: 2]) & lowGen[4*g+1])
                      | ((&lowProp[4*g+1 +: 3]) & lowGen[4*g])
                      | ((&lowProp[4*g +: 4]) & grpCarry[g]);
    end
  end

  assign lowSum = lowProp ^ lowCarry;

  // The MSB is split off so its carry-in is visible for the overflow test.
  assign upperLow   = {1'b0, aHi_q[HALF-2:0]} + {1'b0, bHi_q[HALF-2:0]}
                    + {{(HALF-1){1'b0}}, midCarry_q};
  assign msbA       = aHi_q[HALF-1];
  assign msbB       = bHi_q[HALF-1];
  assign msbCarryIn = upperLow[HALF-1];
  assign msbSum     = msbA ^ msbB ^ msbCarryIn;
  assign carryOut   = (msbA & msbB) | (msbCarryIn & (msbA ^ msbB));
  assign overflow   = msbCarryIn ^ carryOut;
  assign rawResult  = {msbSum, upperLow[HALF-2:0], lowSum_q};

  always_comb begin
    result_d = rawResult;
    if (sat_q && overflow) begin
      result_d = msbA ? SAT_MIN : SAT_MAX;
    end
    flagN_d = result_d[WIDTH-1];
    flagZ_d = (result_d == '0);
    flagV_d = overflow;
    flagC_d = carryOut;
  end

  assign s2Adv      = !outValid_q || bus.out_ready;
  assign s1Adv      = !s1Valid_q || s2Adv;
  assign s1Load     = bus.in_valid && s1Adv;
  assign s2Load     = s1Valid_q && s2Adv;
  assign s1Valid_d  = s1Adv ? s1Load : s1Valid_q;
  assign outValid_d = s2Adv ? s1Valid_q : outValid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      lowSum_q   <= '0;
      aHi_q      <= '0;
      bHi_q      <= '0;
      midCarry_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      if (s1Load) begin
        lowSum_q   <= lowSum;
        midCarry_q <= grpCarry[NGROUPS];
        aHi_q      <= bus.a[WIDTH-1:HALF];
        bHi_q      <= bEff[WIDTH-1:HALF];
        sat_q      <= bus.sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      flagN_q    <= 1'b0;
      flagZ_q    <= 1'b0;
      flagV_q    <= 1'b0;
      flagC_q    <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      if (s2Load) begin
        result_q <= result_d;
        flagN_q  <= flagN_d;
        flagZ_q  <= flagZ_d;
        flagV_q  <= flagV_d;
        flagC_q  <= flagC_d;
      end
    end
  end

  assign bus.in_ready  = s1Adv;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.flag_n    = flagN_q;
  assign bus.flag_z    = flagZ_q;
  assign bus.flag_v    = flagV_q;
  assign bus.flag_c    = flagC_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed-vector bench for add_sub_pipe: a 16-bit instance for the main behaviour
// and an 8-bit instance for the narrow-build corner cases.
module tb_add_sub_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  add_sub_pipe_if #(.WIDTH(16)) if16 ();
  add_sub_pipe_if #(.WIDTH(8))  if8 ();

  add_sub_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  add_sub_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic sub, input logic sat);
    if16.in_valid = 1'b1;
    if16.a        = a;
    if16.b        = b;
    if16.sub      = sub;
    if16.sat      = sat;
  endtask

  // One isolated beat: accepted at the next edge, visible after the following edge.
  task automatic runOne16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic sat,
                          input logic [15:0] expResult, input logic [3:0] expNzvc);
    @(negedge clk);
    applyStimulus(a, b, sub, sat);
    #1;
    checkOutput({tag, ".in_ready"}, 32'(if16.in_ready), 32'd1);
    @(negedge clk);
    if16.in_valid = 1'b0;
    checkOutput({tag, ".early"}, 32'(if16.out_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".valid"}, 32'(if16.out_valid), 32'd1);
    checkOutput({tag, ".result"}, 32'(if16.result), 32'(expResult));
    checkOutput({tag, ".nzvc"},
                32'({if16.flag_n, if16.flag_z, if16.flag_v, if16.flag_c}), 32'(expNzvc));
    @(negedge clk);
    checkOutput({tag, ".drained"}, 32'(if16.out_valid), 32'd0);
  endtask

  task automatic runOne8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic sat,
                         input logic [7:0] expResult, input logic [3:0] expNzvc);
    @(negedge clk);
    if8.in_valid = 1'b1;
    if8.a        = a;
    if8.b        = b;
    if8.sub      = sub;
    if8.sat      = sat;
    @(negedge clk);
    if8.in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".valid"}, 32'(if8.out_valid), 32'd1);
    checkOutput({tag, ".result"}, 32'(if8.result), 32'(expResult));
    checkOutput({tag, ".nzvc"},
                32'({if8.flag_n, if8.flag_z, if8.flag_v, if8.flag_c}), 32'(expNzvc));
  endtask

  // Streams 8 beats; out_ready is dropped for stallLen cycles starting at cycle stallStart.
  task automatic streamBeats(input string tag, input int stallStart, input int stallLen);
    int          sent     = 0;
    int          got      = 0;
    int          inflight = 0;
    logic [15:0] av, bv, ev;
    logic        sv;
    for (int t = 0; t < 40 && got < 8; t++) begin
      @(negedge clk);
      if16.out_ready = !(t >= stallStart && t < stallStart + stallLen);
      if (sent < 8) begin
        av = 16'h1000 + 16'(sent) * 16'h0123;
        bv = 16'h0F00 - 16'(sent) * 16'h0011;
        sv = sent[0];
        applyStimulus(av, bv, sv, 1'b0);
      end else begin
        if16.in_valid = 1'b0;
      end
      #1;
      checkOutput({tag, ".in_ready"}, 32'(if16.in_ready),
                  32'(!(inflight == 2 && !if16.out_ready)));
      if (stallStart < 0) begin
        checkOutput({tag, ".out_valid"}, 32'(if16.out_valid), 32'(t >= 2 && t < 10));
      end
      if (if16.out_valid && !if16.out_ready && expQ.size() > 0) begin
        checkOutput({tag, ".hold"}, 32'(if16.result), 32'(expQ[0]));
      end
      if (if16.out_valid && if16.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput({tag, ".extra"}, 32'(expQ.size()), 32'd1);
        end else begin
          checkOutput({tag, ".data"}, 32'(if16.result), 32'(expQ.pop_front()));
        end
        got++;
        inflight--;
      end
      if (if16.in_valid && if16.in_ready) begin
        ev = sv ? 16'(av - bv) : 16'(av + bv);
        expQ.push_back(ev);
        sent++;
        inflight++;
      end
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    checkOutput({tag, ".count"}, 32'(got), 32'd8);
    checkOutput({tag, ".leftover"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    if16.in_valid  = 1'b0;
    if16.a         = '0;
    if16.b         = '0;
    if16.sub       = 1'b0;
    if16.sat       = 1'b0;
    if16.out_ready = 1'b1;
    if8.in_valid   = 1'b0;
    if8.a          = '0;
    if8.b          = '0;
    if8.sub        = 1'b0;
    if8.sat        = 1'b0;
    if8.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.out_valid", 32'(if16.out_valid), 32'd0);
    checkOutput("reset.result", 32'(if16.result), 32'd0);
    checkOutput("reset.nzvc", 32'({if16.flag_n, if16.flag_z, if16.flag_v, if16.flag_c}), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset.in_ready", 32'(if16.in_ready), 32'd1);

    runOne16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b1010);
    runOne16("add_sat",    16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0010);
    runOne16("sub_sat",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1011);
    runOne16("sub_zero",   16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 4'b0101);
    runOne16("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b0101);
    runOne16("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 4'b1000);
    runOne16("add_negsat", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 4'b1011);

    streamBeats("stream", -1, 0);
    streamBeats("stall", 4, 3);

    @(negedge clk);
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(16'h3333, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    if16.in_valid = 1'b0;
    rst           = 1'b1;
    #1;
    checkOutput("rst_mid.out_valid", 32'(if16.out_valid), 32'd0);
    checkOutput("rst_mid.result", 32'(if16.result), 32'd0);
    checkOutput("rst_mid.nzvc", 32'({if16.flag_n, if16.flag_z, if16.flag_v, if16.flag_c}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid.in_ready", 32'(if16.in_ready), 32'd1);
    runOne16("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 4'b0000);

    runOne8("w8_sat",    8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 4'b0010);
    runOne8("w8_ovf",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b1010);
    runOne8("w8_borrow", 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
